// File: rtl/pool_pkg.sv
// Definitions shared between the max-pool and max-unpool stages.
package pool_pkg;

    localparam int CTRL_EN_BIT = 6;
    localparam int CTRL_W_MSB  = 5;
    localparam int POOL_MAX_W  = 64;

    typedef enum logic {
        ROW_A,
        ROW_B
    } state_e;

    // Row width field encodes 64 as 0, so the 6-bit wrap of w-1 yields 63.
    function automatic logic [CTRL_W_MSB:0] pool_last_col(input logic [CTRL_W_MSB:0] w);
        return w - 1'b1;
    endfunction

endpackage

// File: rtl/unpool_row_buf.sv
// Row buffer: POOL_MAX_W entries, synchronous write, asynchronous read, no reset.
module unpool_row_buf
    import pool_pkg::*;
#(
    parameter int BW = 48
) (
    input  logic                          clk,
    input  logic                          we_i,
    input  logic [$clog2(POOL_MAX_W)-1:0] waddr_i,
    input  logic [BW-1:0]                 wdata_i,
    input  logic [$clog2(POOL_MAX_W)-1:0] raddr_i,
    output logic [BW-1:0]                 rdata_o
);

    logic [BW-1:0] mem_q [POOL_MAX_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/max_unpool.sv
// Nearest-neighbour 2x2 upsampler with bypass; define MAX_UNPOOL_VDUP_EN for
// vertical duplication (row buffer + ROW_B), otherwise horizontal 1x2 only.
module max_unpool
    import pool_pkg::*;
#(
    parameter int DW = 8,
    parameter int DN = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DN*DW-1:0]       m_data,
    input  logic                   m_valid,
    output logic                   m_ready,
    input  logic [CTRL_EN_BIT:0]   m_ctrl,
    output logic [DN*DW-1:0]       s_data,
    output logic                   s_valid,
    input  logic                   s_ready
);

    localparam int BW = DN * DW;

    state_e                state_q, state_d;
    logic [CTRL_W_MSB:0]   col_q, col_d;
    logic                  phase_q, phase_d;
    logic [BW-1:0]         hold_q, hold_d;
    logic [BW-1:0]         s_data_q, s_data_d;
    logic                  s_valid_q, s_valid_d;
    logic                  en_q, en_d;
    logic [CTRL_W_MSB:0]   w_q, w_d;
    logic                  run_q;

    logic                  slot_free;
    logic                  boundary;
    logic                  cur_en;
    logic                  load;
    logic [CTRL_W_MSB:0]   last_col;

`ifdef MAX_UNPOOL_VDUP_EN
    logic                  buf_we;
    logic [BW-1:0]         buf_rdata;

    unpool_row_buf #(.BW(BW)) u_row_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (col_q),
        .wdata_i (m_data),
        .raddr_i (col_q),
        .rdata_o (buf_rdata)
    );
`endif

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        phase_d  = phase_q;
        hold_d   = hold_q;
        s_data_d = s_data_q;
        en_d     = en_q;
        w_d      = w_q;
        load     = 1'b0;
        m_ready  = 1'b0;
`ifdef MAX_UNPOOL_VDUP_EN
        buf_we   = 1'b0;
`endif

        slot_free = !s_valid_q || s_ready;
        boundary  = (state_q == ROW_A) && (col_q == '0) && !phase_q;

        // Control is live at the row-pair boundary and frozen everywhere else.
        if (boundary) begin
            en_d = m_ctrl[CTRL_EN_BIT];
            w_d  = m_ctrl[CTRL_W_MSB:0];
        end
        cur_en   = en_d;
        last_col = pool_last_col(w_d);

        if (run_q) begin
            if (!cur_en) begin
                m_ready = slot_free;
                if (m_valid && slot_free) begin
                    load     = 1'b1;
                    s_data_d = m_data;
                end
            end else begin
                unique case (state_q)
                    ROW_A: begin
                        if (!phase_q) begin
                            m_ready = slot_free;
                            if (m_valid && slot_free) begin
                                load     = 1'b1;
                                s_data_d = m_data;
                                hold_d   = m_data;
                                phase_d  = 1'b1;
`ifdef MAX_UNPOOL_VDUP_EN
                                buf_we   = 1'b1;
`endif
                            end
                        end else if (slot_free) begin
                            load     = 1'b1;
                            s_data_d = hold_q;
                            phase_d  = 1'b0;
                            if (col_q == last_col) begin
                                col_d = '0;
`ifdef MAX_UNPOOL_VDUP_EN
                                state_d = ROW_B;
`endif
                            end else begin
                                col_d = col_q + 1'b1;
                            end
                        end
                    end
                    ROW_B: begin
`ifdef MAX_UNPOOL_VDUP_EN
                        if (slot_free) begin
                            load     = 1'b1;
                            s_data_d = buf_rdata;
                            phase_d  = !phase_q;
                            if (phase_q) begin
                                if (col_q == last_col) begin
                                    col_d   = '0;
                                    state_d = ROW_A;
                                end else begin
                                    col_d = col_q + 1'b1;
                                end
                            end
                        end
`else
                        state_d = ROW_A;
`endif
                    end
                    default: state_d = ROW_A;
                endcase
            end
        end

        s_valid_d = load ? 1'b1 : (s_ready ? 1'b0 : s_valid_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ROW_A;
            col_q     <= '0;
            phase_q   <= 1'b0;
            hold_q    <= '0;
            s_data_q  <= '0;
            s_valid_q <= 1'b0;
            en_q      <= 1'b0;
            w_q       <= '0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            phase_q   <= phase_d;
            hold_q    <= hold_d;
            s_data_q  <= s_data_d;
            s_valid_q <= s_valid_d;
            en_q      <= en_d;
            w_q       <= w_d;
            run_q     <= 1'b1;
        end
    end

    assign s_data  = s_data_q;
    assign s_valid = s_valid_q;

endmodule

// File: doc/max_unpool.md
# max_unpool

Nearest-neighbour 2x2 upsampler for the pooling datapath; the inverse of the 2x2 max-pool stage. Each input beat carries DN parallel channels of DW bits; every beat is emitted twice horizontally and every input row is replayed twice vertically from an internal row buffer. It sits between a feature-map source and the convolution array. Both sides use valid/ready handshakes. A bypass mode passes beats through unchanged.

## Interface
- DW, 8, bits per channel lane
- DN, 6, channels per beat; beat width DN*DW
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- m_data  in  DN*DW  input beat
- m_valid  in  1  input beat valid
- m_ready  out  1  input beat accepted when m_valid && m_ready
- m_ctrl  in  7  [6] unpool enable, [5:0] input beats per row (0 encodes 64)
- s_data  out  DN*DW  output beat, registered
- s_valid  out  1  output valid, registered
- s_ready  in  1  downstream ready

## Operation
- States: ROW_A (accept input row, emit each beat twice, write row buffer) and ROW_B (replay row buffer, each entry twice, no input accepted).
- Counters: col (6 bits, 0..W-1) and phase (1 bit, copy 0/1). W = m_ctrl[5:0], with 0 meaning 64.
- m_ctrl is sampled only at a row-pair boundary: ROW_A, col==0, phase==0. The sampled en and W are held until ROW_B completes. Changes at any other time are ignored.
- Output register advances when !s_valid || s_ready ("slot free").
- ROW_A, phase 0:
  - m_ready = slot free.
  - On accept: s_data <= m_data; buf[col] <= m_data; hold register <= m_data; phase <= 1.
- ROW_A, phase 1:
  - m_ready = 0.
  - When slot free: s_data <= hold; phase <= 0.
  - If col==W-1: col <= 0 and state <= ROW_B; else col++.
- ROW_B:
  - When slot free: s_data <= buf[col]; phase toggles.
  - On phase 1: col++. At col==W-1 with phase 1: col <= 0 and state <= ROW_A.
- Bypass (sampled en=0): m_ready = slot free; on accept s_data <= m_data; states and counters stay idle.
- s_valid is set on any load and cleared when s_ready && !new load.

## Timing
- Reset values: s_valid=0, s_data=0, m_ready=0 during reset, state=ROW_A, col=0, phase=0, hold=0. Row buffer contents are don't-care.
- Latency is 1 cycle from input accept to first copy on s_data.
- Unpool throughput with s_ready held high: 1 output/cycle; input accepted at most every 2nd cycle during ROW_A; no input for W*2 cycles during ROW_B.
- Bypass throughput: 1 beat/cycle.
- s_data and s_valid are stable while s_valid && !s_ready.
- Reset mid-row discards partial rows; after release the block restarts at ROW_A, col 0.
- W=1: sequence is A,A then A,A. W=64: full buffer, col wraps 63 -> 0.

## Configuration
- MAX_UNPOOL_VDUP_EN defined: full 2x2 behaviour; ROW_B and the 64-entry row buffer are present.
- Not defined: horizontal 1x2 only. ROW_B and the buffer are removed. After ROW_A col==W-1 phase 1, the block returns directly to the row-pair boundary (col 0, phase 0). Bypass is unchanged.

## Structure
- Shared package pool_pkg:
  - CTRL_EN_BIT=6
  - CTRL_W_MSB=5
  - POOL_MAX_W=64
  - state enum {ROW_A, ROW_B}
  - These are shared with the max-pool stage.
- Sub-module unpool_row_buf: 64 x DN*DW, one synchronous write port, one asynchronous read port, no reset on storage.

## Test plan
- DN=6, DW=8, en=1, W=2; inputs A,B (row 1), C,D (row 2); s_ready=1 -> s_data order A,A,B,B,A,A,B,B,C,C,D,D,C,C,D,D; m_ready low throughout each replay.
- Same stimulus with s_ready toggling at random -> identical sequence; s_data never changes while s_valid && !s_ready.
- en=0, 10 back-to-back beats, s_ready=1 -> beats out unchanged, 1 cycle latency, 1 beat/cycle.
- m_ctrl W=0 -> 64 beats in -> 256 beats out; buffer index wraps correctly.
- Assert rst_n low mid-ROW_B -> s_valid=0 next cycle. After release, new row W=1 input E -> E,E,E,E.
- Macro undefined, W=2, inputs A,B,C,D -> A,A,B,B,C,C,D,D.
